sram_resp: RTL and testbench

Memory responder for the core's fetch and load/store initiators. It terminates an AXI4-Lite-style valid/ready read channel and write channel on a word-addressed on-chip array. Response latency is configurable, so the fetch and memory stages are exercised against a non-ideal slave. It sits below the instruction-fetch and data-memory initiators and replaces the zero-latency combinational memory model.

---
 rtl/npc_bus_pkg.sv | 18 +
 rtl/sram_resp_lfsr8.sv | 26 ++
 rtl/sram_resp.sv | 173 +++++++++++++++++
 tb/tb_sram_resp.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_bus_pkg.sv
// Shared bus definitions for the core's memory-side responders: response codes
// and the state encoding of the sram_resp transaction FSM.
package npc_bus_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_RD_WAIT = 3'd1;
  localparam state_t ST_RD_RESP = 3'd2;
  localparam state_t ST_WR_WAIT = 3'd3;
  localparam state_t ST_WR_RESP = 3'd4;

endpackage

// File: rtl/sram_resp_lfsr8.sv
// 8-bit Galois LFSR, polynomial x^8+x^6+x^5+x^4+1, seeded with 8'h5A on reset.
// Used by sram_resp to jitter response latency when SRAM_RAND_DELAY_EN is defined.
module lfsr8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  // Right-shifting Galois form: tap mask 8'hB8 encodes x^8+x^6+x^5+x^4+1.
  always_comb begin
    q_d = q_q;
    if (en) q_d = {1'b0, q_q[7:1]} ^ (q_q[0] ? 8'hB8 : 8'h00);
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= 8'h5A;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/sram_resp.sv
// Word-addressed on-chip SRAM behind valid/ready read and write channels with
// configurable response latency; SRAM_RAND_DELAY_EN adds LFSR jitter to it.
module sram_resp
  import npc_bus_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH_LOG2 = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                    LATENCY    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int CNT_W  = $clog2(LATENCY + 17);

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] word;
    word = (a - BASE_ADDR) >> 2;
    return (a >= BASE_ADDR) && (word < ADDR_WIDTH'(DEPTH));
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] word;
    word = (a - BASE_ADDR) >> 2;
    return DEPTH_LOG2'(word);
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  arready_q, rvalid_q, bvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  resp_e                 rresp_q, bresp_q;
  logic [CNT_W-1:0]      lat_load;
  logic                  rd_go, wr_go, rd_enter, wr_enter;

`ifdef SRAM_RAND_DELAY_EN
  logic [7:0] lfsr;
  logic       unused_lfsr_hi;

  lfsr8 u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .q   (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[7:4];
  assign lat_load       = CNT_W'(LATENCY) + CNT_W'(lfsr[3:0]);
`else
  assign lat_load = CNT_W'(LATENCY);
`endif

  // The registered idle flag is qualified by the live inputs so a read arriving
  // in the same cycle pre-empts the write without a handshake on AW/W.
  assign rd_go   = arready_q & arvalid;
  assign wr_go   = arready_q & awvalid & wvalid & ~arvalid;
  assign awready = wr_go;
  assign wready  = wr_go;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_go) begin
          idx_d   = addr_idx(araddr);
          err_d   = ~addr_ok(araddr);
          cnt_d   = lat_load;
          state_d = (lat_load == '0) ? ST_RD_RESP : ST_RD_WAIT;
        end else if (wr_go) begin
          idx_d   = addr_idx(awaddr);
          err_d   = ~addr_ok(awaddr);
          wdata_d = wdata;
          wstrb_d = wstrb;
          cnt_d   = lat_load;
          state_d = (lat_load == '0) ? ST_WR_RESP : ST_WR_WAIT;
        end
      end
      ST_RD_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_d == '0) state_d = ST_RD_RESP;
      end
      ST_WR_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_d == '0) state_d = ST_WR_RESP;
      end
      ST_RD_RESP: if (rready) state_d = ST_IDLE;
      ST_WR_RESP: if (bready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  assign rd_enter = (state_d == ST_RD_RESP) && (state_q != ST_RD_RESP);
  assign wr_enter = (state_d == ST_WR_RESP) && (state_q != ST_WR_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      bresp_q   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      arready_q <= (state_d == ST_IDLE);
      rvalid_q  <= (state_d == ST_RD_RESP);
      bvalid_q  <= (state_d == ST_WR_RESP);
      if (rd_enter) begin
        rdata_q <= err_d ? '0 : mem_q[idx_d];
        rresp_q <= err_d ? RESP_DECERR : RESP_OKAY;
      end
      if (wr_enter) bresp_q <= err_d ? RESP_DECERR : RESP_OKAY;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q   <= cnt_d;
    idx_q   <= idx_d;
    err_q   <= err_d;
    wdata_q <= wdata_d;
    wstrb_q <= wstrb_d;
  end

  // Array contents survive reset; a reset on the commit edge drops the write.
  always_ff @(posedge clk) begin
    if (!rst && wr_enter && !err_d) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb_d[b]) mem_q[idx_d][b*8 +: 8] <= wdata_d[b*8 +: 8];
      end
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;

endmodule

// File: tb/tb_sram_resp.sv
// Self-checking bench for sram_resp: directed transactions plus a per-cycle
// monitor comparing against a word-level memory model and latency window.
module tb_sram_resp;

`ifdef SRAM_RAND_DELAY_EN
  localparam int LAT    = 0;
  localparam int JITTER = 15;
  localparam int NREAD  = 100;
`else
  localparam int LAT    = 1;
  localparam int JITTER = 0;
  localparam int NREAD  = 20;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0;
  logic        rready = 1'b1, bready = 1'b1;
  logic [3:0]  wstrb = '0;
  logic        arready, rvalid, awready, wready, bvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  sram_resp #(.LATENCY(LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mdl [int];

  function automatic bit in_range(input logic [31:0] a);
    return (a >= 32'h8000_0000) && (a <= 32'h8000_3FFF);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - 32'h8000_0000) / 4);
  endfunction

  typedef struct {
    int          hs;
    bit          known;
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  typedef struct {
    int          hs;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
  } bexp_t;

  rexp_t rq[$];
  bexp_t bq[$];
  bit          r_hold = 0, b_hold = 0;
  logic [31:0] r_prev;
  logic [1:0]  rr_prev, br_prev;

  always @(negedge clk) begin
    if (rst) begin
      rq.delete();
      bq.delete();
      r_hold = 0;
      b_hold = 0;
    end else begin
      check("awready_eq_wready", awready, wready);
      if (arvalid) check("write_yields_to_read", awready, 1'b0);

      if (arvalid && arready) begin
        rexp_t e;
        e.hs = cyc;
        if (in_range(araddr)) begin
          e.known = mdl.exists(word_of(araddr));
          e.data  = e.known ? mdl[word_of(araddr)] : 32'h0;
          e.resp  = 2'b00;
        end else begin
          e.known = 1;
          e.data  = 32'h0;
          e.resp  = 2'b11;
        end
        rq.push_back(e);
      end

      if (awvalid && wvalid && awready && wready) begin
        bexp_t e;
        e.hs   = cyc;
        e.addr = awaddr;
        e.data = wdata;
        e.strb = wstrb;
        e.resp = in_range(awaddr) ? 2'b00 : 2'b11;
        bq.push_back(e);
      end

      if (r_hold) begin
        check("rvalid_held", rvalid, 1'b1);
        check("rdata_held", rdata, r_prev);
        check("rresp_held", rresp, rr_prev);
      end else if (rvalid) begin
        if (rq.size() == 0) check("rvalid_spurious", rvalid, 1'b0);
        else begin
          int d;
          d = cyc - rq[0].hs;
          check("r_latency_window", (d >= 1 + LAT) && (d <= 1 + LAT + JITTER), 1'b1);
          if (rq[0].known) check("rdata_model", rdata, rq[0].data);
          check("rresp_model", rresp, rq[0].resp);
        end
      end
      if (rvalid && rready && rq.size() > 0) void'(rq.pop_front());
      r_hold  = rvalid && !rready;
      r_prev  = rdata;
      rr_prev = rresp;

      if (b_hold) begin
        check("bvalid_held", bvalid, 1'b1);
        check("bresp_held", bresp, br_prev);
      end else if (bvalid) begin
        if (bq.size() == 0) check("bvalid_spurious", bvalid, 1'b0);
        else begin
          int d;
          d = cyc - bq[0].hs;
          check("b_latency_window", (d >= 1 + LAT) && (d <= 1 + LAT + JITTER), 1'b1);
          check("bresp_model", bresp, bq[0].resp);
        end
      end
      if (bvalid && bready && bq.size() > 0) begin
        bexp_t e;
        e = bq.pop_front();
        if (in_range(e.addr)) begin
          logic [31:0] w;
          w = mdl.exists(word_of(e.addr)) ? mdl[word_of(e.addr)] : 32'h0;
          for (int b = 0; b < 4; b++) if (e.strb[b]) w[b*8 +: 8] = e.data[b*8 +: 8];
          mdl[word_of(e.addr)] = w;
        end
      end
      b_hold  = bvalid && !bready;
      br_prev = bresp;
    end
  end

  // ---------------- drivers ----------------
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 300);
    if (!awready) check("aw_accept_timeout", awready, 1'b1);
    @(posedge clk); #1 awvalid = 0; wvalid = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bvalid && n < 300);
    if (!bvalid) check("b_arrive_timeout", bvalid, 1'b1);
    resp = bresp;
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                         output int lat);
    int n, h;
    araddr = a; arvalid = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 300);
    if (!arready) check("ar_accept_timeout", arready, 1'b1);
    h = cyc;
    @(posedge clk); #1 arvalid = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rvalid && n < 300);
    if (!rvalid) check("r_arrive_timeout", rvalid, 1'b1);
    d = rdata; resp = rresp; lat = cyc - h;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          lat, n, rhs, whs;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_arready", arready, 1'b0);
    check("reset_rvalid", rvalid, 1'b0);
    check("reset_bvalid", bvalid, 1'b0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_rresp_bresp", {rresp, bresp}, 4'h0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("arready_low_until_edge", arready, 1'b0);
    @(negedge clk);
    check("arready_first_cycle", arready, 1'b1);
    @(posedge clk); #1;

    // full-word write and read-back
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, r);
    check("full_write_bresp", r, 2'b00);
    do_read(32'h8000_0010, d, r, lat);
    check("full_read_data", d, 32'hDEAD_BEEF);
    check("full_read_rresp", r, 2'b00);
    if (JITTER == 0) check("read_latency_2", lat, 2);

    // byte-lane merge
    do_write(32'h8000_0020, 32'h1122_3344, 4'hF, r);
    do_write(32'h8000_0022, 32'h0000_AA00, 4'b0010, r);
    do_read(32'h8000_0020, d, r, lat);
    check("partial_write_merge", d, 32'h1122_AA44);

    // out-of-range accesses
    do_write(32'h8000_0000, 32'h0BAD_F00D, 4'hF, r);
    do_read(32'h7FFF_FFFC, d, r, lat);
    check("below_base_rresp", r, 2'b11);
    check("below_base_rdata", d, 32'h0);
    do_write(32'h8000_4000, 32'hCAFE_BABE, 4'hF, r);
    check("above_top_bresp", r, 2'b11);
    do_read(32'h8000_0000, d, r, lat);
    check("decerr_write_no_alias", d, 32'h0BAD_F00D);
    do_read(32'h8000_0010, d, r, lat);
    check("array_unchanged", d, 32'hDEAD_BEEF);
    do_write(32'h8000_3FFC, 32'h7777_0001, 4'hF, r);
    check("last_word_bresp", r, 2'b00);
    do_read(32'h8000_3FFC, d, r, lat);
    check("last_word_data", d, 32'h7777_0001);

    // read and write raised together, read response back-pressured
    rready = 0;
    araddr = 32'h8000_0010; arvalid = 1;
    awaddr = 32'h8000_0024; wdata = 32'h55AA_55AA; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 300);
    check("collide_ar_accepted", arready, 1'b1);
    @(posedge clk); #1 arvalid = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rvalid && n < 300);
    check("collide_rvalid", rvalid, 1'b1);
    check("collide_rdata", rdata, 32'hDEAD_BEEF);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      check("write_blocked_during_read", awready, 1'b0);
    end
    @(posedge clk); #1 rready = 1;
    @(negedge clk);
    rhs = cyc;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 300);
    whs = cyc;
    check("collide_write_accepted", awready, 1'b1);
    check("write_after_read", whs > rhs, 1'b1);
    @(posedge clk); #1 awvalid = 0; wvalid = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bvalid && n < 300);
    check("collide_bresp", {bvalid, bresp}, 3'b100);
    @(posedge clk); #1;
    do_read(32'h8000_0024, d, r, lat);
    check("collide_write_data", d, 32'h55AA_55AA);

    // reset in the middle of a write drops it
    do_write(32'h8000_0030, 32'h1234_5678, 4'hF, r);
    awaddr = 32'h8000_0030; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 300);
    @(posedge clk); #1 awvalid = 0; wvalid = 0; rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (3) begin
      @(negedge clk);
      check("no_bvalid_after_reset", bvalid, 1'b0);
    end
    @(posedge clk); #1;
    do_read(32'h8000_0030, d, r, lat);
    check("aborted_write_lost", d, 32'h1234_5678);

    // streaming reads over a small table
    for (int i = 0; i < 16; i++)
      do_write(32'h8000_0100 + 4 * i, (32'h0101_0101 * i) ^ 32'hA5A5_A5A5, 4'hF, r);
    for (int i = 0; i < NREAD; i++) begin
      do_read(32'h8000_0100 + 4 * (i % 16), d, r, lat);
      check("stream_data", d, (32'h0101_0101 * (i % 16)) ^ 32'hA5A5_A5A5);
    end
    do_read(32'h8000_0104, d, r, lat);
    check("stream_pin_word1", d, 32'hA4A4_A4A4);

    repeat (3) @(negedge clk);
    check("queues_drained", rq.size() + bq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
